// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO without a
// simultaneous pop is dropped and flagged with a one-cycle overflow pulse.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic          w_full, w_empty, w_pop, w_wr;

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = i_push & (~w_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_overflow <= i_push & w_full & ~w_pop;
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_valid    = ~w_empty;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin sync, clock glitch filter, frame FSM, timeout.
// Define PS2_BREAK_FILTER_EN to drop break codes (0xF0 and the byte after it).
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (strobe with data low)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and odd parity, then push or flag error
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ps2_clk,
  input  logic                          i_ps2_data,
  output logic [7:0]                    o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int              TW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LOAD      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      LAST_DATA_BIT = 3'(PS2_FRAME_BITS - 4);

  logic [1:0]            r_clk_sync, r_dat_sync;
  logic [FILTER_LEN-1:0] r_filt_sr;
  logic [FILTER_LEN-1:0] w_filt_sr_next;
  logic                  r_filt_clk, w_filt_clk_next;
  logic                  r_strobe;
  logic                  w_bit;

  ps2_state_t            r_state, w_state_next;
  logic [7:0]            r_shift;
  logic [2:0]            r_bit_cnt;
  logic                  r_parity;
  logic [TW-1:0]         r_tmo_cnt;
  logic                  w_good, w_err, w_drop;
  logic                  r_frame_err, r_push;
  logic [7:0]            r_push_data;

  assign w_filt_sr_next = {r_filt_sr[FILTER_LEN-2:0], r_clk_sync[1]};
  assign w_bit          = r_dat_sync[1];

  always_comb begin
    w_filt_clk_next = r_filt_clk;
    if (w_filt_sr_next == '0)      w_filt_clk_next = 1'b0;
    else if (&w_filt_sr_next)      w_filt_clk_next = 1'b1;
  end

  // Sync flops and filter start idle-high so reset never fakes a falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt_sr  <= '1;
      r_filt_clk <= 1'b1;
      r_strobe   <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_filt_sr  <= w_filt_sr_next;
      r_filt_clk <= w_filt_clk_next;
      r_strobe   <= r_filt_clk & ~w_filt_clk_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_good       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE:   if (r_strobe && !w_bit) w_state_next = ST_DATA;
      ST_DATA:   if (r_strobe && r_bit_cnt == LAST_DATA_BIT) w_state_next = ST_PARITY;
      ST_PARITY: if (r_strobe) w_state_next = ST_STOP;
      ST_STOP: begin
        if (r_strobe) begin
          w_state_next = ST_IDLE;
          if (w_bit && (^{r_parity, r_shift})) w_good = 1'b1;
          else                                  w_err  = 1'b1;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && !r_strobe && r_tmo_cnt == '0) begin
      w_state_next = ST_IDLE;
      w_good       = 1'b0;
      w_err        = 1'b1;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic r_brk_flag;

  assign w_drop = (r_shift == PS2_BREAK_CODE) ||
                  (r_brk_flag && r_shift != PS2_EXT_CODE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_brk_flag <= 1'b0;
    else if (w_err)  r_brk_flag <= 1'b0;
    else if (w_good) begin
      if (r_shift == PS2_BREAK_CODE)    r_brk_flag <= 1'b1;
      else if (r_shift != PS2_EXT_CODE) r_brk_flag <= 1'b0;
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_parity    <= 1'b0;
      r_tmo_cnt   <= TMO_LOAD;
      r_frame_err <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      if (r_strobe) begin
        case (r_state)
          ST_IDLE: begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
          end
          ST_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          ST_PARITY: r_parity <= w_bit;
          default:   r_parity <= r_parity;
        endcase
      end
      // Down-counter reloads on each strobe; reaching zero mid-frame is the timeout.
      if (r_state == ST_IDLE || r_strobe) r_tmo_cnt <= TMO_LOAD;
      else if (r_tmo_cnt != '0)           r_tmo_cnt <= r_tmo_cnt - 1'b1;
      r_frame_err <= w_err;
      r_push      <= w_good & ~w_drop;
      r_push_data <= r_shift;
    end
  end

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (r_push),
    .i_data     (r_push_data),
    .i_pop      (i_rx_ready),
    .o_data     (o_rx_data),
    .o_valid    (o_rx_valid),
    .o_level    (o_fifo_level),
    .o_overflow (o_overflow)
  );

  assign o_frame_err = r_frame_err;

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver that turns the raw `ps2_clk`/`ps2_data` pins into validated scan-code bytes. It feeds the keyboard side of `io_interface` through a small byte FIFO with a valid/ready handshake, so the processor can read keys at its own pace. Responsibilities: pin synchronisation, clock filtering, frame deserialisation, parity and stop checking, and timeout recovery.

## Interface
- `FILTER_LEN`, default 8: `ps2_clk` glitch-filter length, in clk samples.
- `TIMEOUT_CYCLES`, default 50000: maximum clk cycles allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- `FIFO_DEPTH`, default 8: byte FIFO depth; must be a power of 2, ≥2.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `rx_data` out 8: byte at the FIFO head.
- `rx_valid` out 1: FIFO not empty; `rx_data` is valid.
- `rx_ready` in 1: consumer pops the head when `rx_valid & rx_ready`.
- `frame_err` out 1: one-cycle pulse on a parity, stop-bit or timeout error.
- `overflow` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through 2 flops.
- **Clock filter:** the synced clock shifts into a `FILTER_LEN`-bit register.
  - Filtered clock goes 0 when all bits are 0 and goes 1 when all bits are 1; otherwise it holds.
  - A registered falling edge of the filtered clock is the sample strobe. Data is sampled from synced `ps2_data` on the strobe.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data=0 → DATA; bit counter=0. Strobe with data=1 → stay in IDLE; ignored, no error.
  - DATA: shift the bit in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: on the strobe, if stop=1 and the 9 bits (data+parity) have odd parity, push the byte; otherwise pulse `frame_err`. Either way → IDLE.
- **Timeout:** a counter clears on every strobe and in IDLE. In any non-IDLE state, reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_err` and discards partial bits.
- **FIFO:** first-word-fall-through.
  - Push when full without a simultaneous pop: byte dropped, `overflow` pulses, contents unchanged.
  - Push and pop in the same cycle when full: both succeed; level unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset (async, any time):** FSM→IDLE; counters and shift registers cleared; FIFO emptied; filter register set to all-ones (idle-high). A frame in progress is lost with no error pulse.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overflow`=0, `fifo_level`=0.
- Pin-to-strobe latency: 2 sync + `FILTER_LEN` filter + 1 edge register, measured in clk cycles.
- Push occurs on the cycle after the stop-bit strobe. `rx_valid` (from empty) is high 2 clk cycles after the stop-bit strobe cycle.
- `frame_err` and `overflow` are high for exactly one cycle per event. Both are registered.
- `rx_data` changes only on a pop or on a push into an empty FIFO.
- Throughput: one pop per cycle; PS/2 byte rate ≪ clk rate.

## Configuration
- `PS2_BREAK_FILTER_EN` defined: a byte 0xF0 is not pushed. It sets a flag, and the next good byte is also discarded, which clears the flag. Only make codes reach the FIFO; 0xE0 is passed through. A `frame_err` or reset clears the flag.
- Undefined: every good byte, including 0xF0 and its successor, is pushed unchanged.

## Structure
- Package `ps2_pkg`:
  - FSM state enum `ps2_state_t`.
  - Constants `PS2_BREAK_CODE`=8'hF0 and `PS2_EXT_CODE`=8'hE0.
  - Frame bit count 11.
- Sub-module `ps2_byte_fifo` (parameter `DEPTH`, width 8): FWFT storage, pointers, level, full/empty, overflow detect. The top holds the sync, filter, FSM and timeout logic.

## Test plan
- Frame 0x1C, parity 0, stop 1, ~12 kHz PS/2 clock → `rx_data`=0x1C with `rx_valid`=1; pop with `rx_ready`=1 → `rx_valid`=0, level 0; no `frame_err`.
- Frame 0x1C with parity 1 → one `frame_err` pulse, `rx_valid` stays 0. Then send 0x32 correctly → 0x32 received.
- 4 bits of a frame, then PS/2 clock held high for `TIMEOUT_CYCLES`+10 → one `frame_err` pulse, FSM idle. Next frame 0x45 → 0x45 received.
- 9 good bytes 0x01..0x09, `rx_ready`=0 → level 8, one `overflow` on the 9th. Pops return 0x01..0x08 in order.
- 1 ns glitches on `ps2_clk` between frames → no strobe, no bytes, no errors.
- Sequence 0x1C, 0xF0, 0x1C → with `PS2_BREAK_FILTER_EN`: FIFO holds only 0x1C (level 1). Without it: 0x1C, 0xF0, 0x1C (level 3). Then assert `rst` mid-frame → all outputs at reset values within 1 cycle.
